// File: rtl/proc_pkg.sv
// Shared types and instruction field positions for the 16-bit processor controller.
package proc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_LOADI = 2'b01,
        CLS_JMP   = 2'b10,
        CLS_HALT  = 2'b11
    } instr_class_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    localparam int CLASS_HI = 15;
    localparam int CLASS_LO = 14;
    localparam int OP_HI    = 13;
    localparam int OP_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 9;
    localparam int RS1_HI   = 8;
    localparam int RS1_LO   = 6;
    localparam int RS2_HI   = 5;
    localparam int RS2_LO   = 3;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;
    localparam int IMM_W    = IMM_HI - IMM_LO + 1;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational split of the instruction register into its fields.
module ctrl_decode
    import proc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PC_W  = 8
) (
    input  logic [WIDTH-1:0] ir,
    output instr_class_t     cls,
    output alu_op_t          op,
    output logic [2:0]       rd,
    output logic [2:0]       rs1,
    output logic [2:0]       rs2,
    output logic [WIDTH-1:0] imm,
    output logic [PC_W-1:0]  target
);

    assign cls    = instr_class_t'(ir[CLASS_HI:CLASS_LO]);
    assign op     = alu_op_t'(ir[OP_HI:OP_LO]);
    assign rd     = ir[RD_HI:RD_LO];
    assign rs1    = ir[RS1_HI:RS1_LO];
    assign rs2    = ir[RS2_HI:RS2_LO];
    assign imm    = {{(WIDTH-IMM_W){1'b0}}, ir[IMM_HI:IMM_LO]};
    assign target = ir[PC_W-1:0];

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Fetch/decode/execute/writeback controller: owns the state register, pc and ir.
// All outputs are Moore-decoded from state, ir and pc.
module proc_ctrl_fsm
    import proc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PC_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [1:0]       alu_opcode,
    output logic [2:0]       rf_raddr1,
    output logic [2:0]       rf_raddr2,
    output logic [2:0]       rf_waddr,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [WIDTH-1:0] imm_out,
    output logic [PC_W-1:0]  pc,
    output logic             halted
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] ir;

    instr_class_t     dec_cls;
    alu_op_t          dec_op;
    logic [2:0]       dec_rd;
    logic [2:0]       dec_rs1;
    logic [2:0]       dec_rs2;
    logic [WIDTH-1:0] dec_imm;
    logic [PC_W-1:0]  dec_target;
    logic             fields_valid;

    ctrl_decode #(
        .WIDTH (WIDTH),
        .PC_W  (PC_W)
    ) u_decode (
        .ir     (ir),
        .cls    (dec_cls),
        .op     (dec_op),
        .rd     (dec_rd),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .imm    (dec_imm),
        .target (dec_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && imem_valid) begin
                ir <= imem_rdata;
            end
            if (state == S_DECODE && dec_cls == CLS_JMP) begin
                pc <= dec_target;
            end else if (state == S_WB) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    // Field outputs are forced to zero outside DECODE..WB so idle/reset outputs stay quiet.
    always_comb begin
        next_state   = state;
        imem_req     = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        fields_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req   = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) next_state = S_DECODE;
            end
            S_DECODE: begin
                fields_valid = 1'b1;
                case (dec_cls)
                    CLS_ALU, CLS_LOADI: next_state = S_EXEC;
                    CLS_JMP:            next_state = S_FETCH;
                    default:            next_state = S_HALT;
                endcase
            end
            S_EXEC: begin
                fields_valid = 1'b1;
                next_state   = S_WB;
            end
            S_WB: begin
                fields_valid = 1'b1;
                rf_we        = 1'b1;
                next_state   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign imem_addr  = pc;
    assign alu_opcode = fields_valid ? dec_op  : ALU_ADD;
    assign rf_raddr1  = fields_valid ? dec_rs1 : 3'd0;
    assign rf_raddr2  = fields_valid ? dec_rs2 : 3'd0;
    assign rf_waddr   = fields_valid ? dec_rd  : 3'd0;
    assign imm_out    = fields_valid ? dec_imm : '0;
    assign wb_sel     = fields_valid && (dec_cls == CLS_LOADI);

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: acts as instruction memory and checks every fetch and writeback
// against an instruction-level model of the program.
module tb_proc_ctrl_fsm;

    localparam int WIDTH = 16;
    localparam int PC_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             imem_valid = 1'b0;
    logic [WIDTH-1:0] imem_rdata = '0;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [1:0]       alu_opcode;
    logic [2:0]       rf_raddr1;
    logic [2:0]       rf_raddr2;
    logic [2:0]       rf_waddr;
    logic             rf_we;
    logic             wb_sel;
    logic [WIDTH-1:0] imm_out;
    logic [PC_W-1:0]  pc;
    logic             halted;

    int checks = 0;
    int errors = 0;
    logic [15:0] mem [256];

    always #5 clk = ~clk;

    proc_ctrl_fsm #(
        .WIDTH (WIDTH),
        .PC_W  (PC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .alu_opcode (alu_opcode),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .imm_out    (imm_out),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyReset();
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_req"},    imem_req,   0);
        checkOutput({tag, "_we"},     rf_we,      0);
        checkOutput({tag, "_pc"},     pc,         0);
        checkOutput({tag, "_addr"},   imem_addr,  0);
        checkOutput({tag, "_halted"}, halted,     0);
        checkOutput({tag, "_op"},     alu_opcode, 0);
        checkOutput({tag, "_ra1"},    rf_raddr1,  0);
        checkOutput({tag, "_ra2"},    rf_raddr2,  0);
        checkOutput({tag, "_wa"},     rf_waddr,   0);
        checkOutput({tag, "_wbsel"},  wb_sel,     0);
        checkOutput({tag, "_imm"},    imm_out,    0);
    endtask

    // Runs one program from a start pulse; the model tracks pc and the in-flight instruction only.
    task automatic applyStimulus(input int nInstr, input int fixedDelay, input bit spurious, input bit resetAtWb);
        int lastReq = 0, nReq = 0, cnt = 0, dly = 1, expGap = 0, expWb = 0, wbCount = 0, haltCycle = 0;
        int budget = nInstr * 12 + 60;
        bit outstanding = 0, haveCur = 0, prevWe = 0, halting = 0, finished = 0;
        logic [7:0]  mpc = 8'h00;
        logic [15:0] cur = 16'h0;
        logic [1:0]  prevOp = 2'b0;
        logic [2:0]  prevRa1 = 3'b0, prevRa2 = 3'b0;

        @(negedge clk);
        start = 1'b1;
        for (int cycle = 1; cycle <= budget && !finished; cycle++) begin
            @(negedge clk);
            start      = halting ? 1'($urandom_range(0, 1)) : (spurious && $urandom_range(0, 7) == 0);
            imem_valid = 1'b0;
            imem_rdata = 16'($urandom);
            if (rf_we) begin
                wbCount++;
                checkOutput("rf_we_single", prevWe, 0);
                if (resetAtWb) begin
                    rst_n = 1'b0;
                    #1;
                    checkQuiet("mid_reset");
                    finished = 1;
                    break;
                end else if (haveCur && cur[15:14] == 2'b00) begin
                    checkOutput("alu_waddr",  rf_waddr,   cur[11:9]);
                    checkOutput("alu_wb_sel", wb_sel,     0);
                    checkOutput("alu_opcode", alu_opcode, cur[13:12]);
                    checkOutput("alu_raddr1", rf_raddr1,  cur[8:6]);
                    checkOutput("alu_raddr2", rf_raddr2,  cur[5:3]);
                    checkOutput("exec_opcode", prevOp,    cur[13:12]);
                    checkOutput("exec_raddr1", prevRa1,   cur[8:6]);
                    checkOutput("exec_raddr2", prevRa2,   cur[5:3]);
                end else if (haveCur && cur[15:14] == 2'b01) begin
                    checkOutput("ldi_waddr",  rf_waddr, cur[11:9]);
                    checkOutput("ldi_wb_sel", wb_sel,   1);
                    checkOutput("ldi_imm",    imm_out,  {8'h00, cur[7:0]});
                end else begin
                    checkOutput("unexpected_we", rf_we, 0);
                end
            end
            prevWe  = rf_we;
            prevOp  = alu_opcode;
            prevRa1 = rf_raddr1;
            prevRa2 = rf_raddr2;
            if (imem_req) begin
                if (halting) begin
                    checkOutput("req_after_halt", imem_req, 0);
                end else begin
                    if (nReq == 0) begin
                        checkOutput("start_to_req", cycle, 1);
                    end else begin
                        checkOutput("fetch_gap", cycle - lastReq, expGap);
                        checkOutput("wb_count",  wbCount, expWb);
                    end
                    checkOutput("req_reissued", outstanding, 0);
                    checkOutput("fetch_addr",   imem_addr, mpc);
                    checkOutput("pc",           pc, mpc);
                    checkOutput("halted_early", halted, 0);
                    nReq++;
                    lastReq = cycle;
                    wbCount = 0;
                    if (nReq > nInstr) begin
                        finished = 1;
                    end else begin
                        outstanding = 1;
                        dly = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 4));
                        cnt = dly;
                    end
                end
            end else if (outstanding) begin
                cnt--;
                if (cnt == 0) begin
                    cur         = mem[mpc];
                    haveCur     = 1;
                    imem_valid  = 1'b1;
                    imem_rdata  = cur;
                    outstanding = 0;
                    case (cur[15:14])
                        2'b00, 2'b01: begin expGap = dly + 4; expWb = 1; mpc = mpc + 8'd1; end
                        2'b10:        begin expGap = dly + 2; expWb = 0; mpc = cur[7:0]; end
                        default:      begin halting = 1; haltCycle = cycle; end
                    endcase
                end
            end else if (spurious && $urandom_range(0, 3) == 0) begin
                imem_valid = 1'b1;
            end
            if (halting && cycle == haltCycle + 2) checkOutput("halted", halted, 1);
            if (halting && cycle == haltCycle + 22) finished = 1;
        end
        start      = 1'b0;
        imem_valid = 1'b0;
        checkOutput("run_completed", finished, 1);
    endtask

    task automatic loadDirected();
        foreach (mem[i]) mem[i] = 16'hC000;
        mem[0]     = 16'h0A50;
        mem[1]     = 16'h46AB;
        mem[2]     = 16'h8010;
        mem[8'h10] = 16'h3E38;
        mem[8'h11] = 16'hC000;
    endtask

    task automatic loadRandom();
        int r;
        foreach (mem[i]) begin
            r = $urandom_range(0, 99);
            if (r < 45)      mem[i] = {2'b00, 14'($urandom)};
            else if (r < 85) mem[i] = {2'b01, 14'($urandom)};
            else if (r < 97) mem[i] = {2'b10, 14'($urandom)};
            else             mem[i] = 16'hC000;
        end
    endtask

    initial begin
        applyReset();
        checkQuiet("reset");

        $display("[TB] directed program, 1-cycle memory");
        loadDirected();
        applyStimulus(10, 1, 0, 0);

        $display("[TB] directed program, 4-cycle stall and stray valids");
        applyReset();
        applyStimulus(10, 4, 1, 0);

        $display("[TB] pc wrap");
        applyReset();
        foreach (mem[i]) mem[i] = 16'hC000;
        mem[0]     = 16'h80FF;
        mem[8'hFF] = 16'h1A50;
        applyStimulus(7, 1, 0, 0);

        $display("[TB] self jump");
        applyReset();
        mem[0] = 16'h8000;
        applyStimulus(6, 0, 1, 0);

        $display("[TB] reset during writeback");
        applyReset();
        loadDirected();
        applyStimulus(10, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checkOutput("idle_no_req", imem_req, 0);
        end
        applyStimulus(3, 1, 0, 0);

        for (int p = 0; p < 4; p++) begin
            $display("[TB] random program %0d", p);
            applyReset();
            loadRandom();
            applyStimulus(40, 0, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
